// File: rtl/nibble_serial_adder_if.sv
// Operand/result handshake bundle for the nibble-serial add/sub unit.
// master drives operands and result acceptance; slave is the adder.
interface nibble_serial_adder_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic             op_sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             overflow;
  logic             zero;

  modport master (
    output in_valid, op_sub, a, b, out_ready,
    input  in_ready, out_valid, result,
    input  carry_out, overflow, zero
  );

  modport slave (
    input  in_valid, op_sub, a, b, out_ready,
    output in_ready, out_valid, result,
    output carry_out, overflow, zero
  );
endinterface

// File: rtl/nibble_serial_adder.sv
// Multi-cycle add/sub engine: one 4-bit adder reused LSB nibble first.
// Carry ripples between cycles through a single register.
module adder4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);
  // 4-bit slice with carry in/out
  assign {co, s} = {1'b0, a} + {1'b0, b} + {4'b0, ci};
endmodule

module nibble_serial_adder #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  nibble_serial_adder_if.slave bus
);
  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] op_a_q;
  logic [WIDTH-1:0] op_b_q;
  logic [WIDTH-1:0] res_q;
  logic [IW-1:0]    idx_q;
  logic             cy_q;
  logic             a_msb_q;
  logic             b_msb_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             carry_q;
  logic             ovf_q;
  logic             zero_q;

  logic [3:0]       sum;
  logic             sum_co;
  logic [WIDTH-1:0] res_nx;
  logic             last;
  logic             accept;

  adder4 u_add (
    .a  (op_a_q[3:0]),
    .b  (op_b_q[3:0]),
    .ci (cy_q),
    .s  (sum),
    .co (sum_co)
  );

  assign res_nx = {sum, res_q[WIDTH-1:4]};
  assign last   = (idx_q == IW'(NIB - 1));
  assign accept = bus.in_valid & in_ready_q;

  // Control FSM plus operand shifters and registered result/flags
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      op_a_q      <= '0;
      op_b_q      <= '0;
      res_q       <= '0;
      idx_q       <= '0;
      cy_q        <= 1'b0;
      a_msb_q     <= 1'b0;
      b_msb_q     <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          in_ready_q <= 1'b1;
          if (accept) begin
            op_a_q     <= bus.a;
            op_b_q     <= bus.op_sub ? ~bus.b : bus.b;
            cy_q       <= bus.op_sub;
            idx_q      <= '0;
            a_msb_q    <= bus.a[WIDTH-1];
            b_msb_q    <= bus.b[WIDTH-1] ^ bus.op_sub;
            in_ready_q <= 1'b0;
            state_q    <= BUSY;
          end
        end
        BUSY: begin
          res_q  <= res_nx;
          op_a_q <= op_a_q >> 4;
          op_b_q <= op_b_q >> 4;
          cy_q   <= sum_co;
          idx_q  <= idx_q + IW'(1);
          if (last) begin
            out_valid_q <= 1'b1;
            carry_q     <= sum_co;
            ovf_q       <= (a_msb_q == b_msb_q) &&
                           (sum[3] != a_msb_q);
            zero_q      <= ~|res_nx;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = res_q;
  assign bus.carry_out = carry_q;
  assign bus.overflow  = ovf_q;
  assign bus.zero      = zero_q;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder (WIDTH=32).
// Driver pushes model results; negedge monitor pops on handshakes.
module tb_nibble_serial_adder;
  localparam int W   = 32;
  localparam int NIB = W / 4;

  typedef struct {
    logic [W-1:0] r;
    logic         c;
    logic         v;
    logic         z;
  } exp_t;

  logic clk;
  logic reset_n;
  int   checks;
  int   failures;
  int   cyc;
  int   last_acc;
  bit   b2b;
  bit   rnd;
  exp_t exp_q[$];
  int   acc_q[$];

  nibble_serial_adder_if #(.WIDTH(W)) bus ();

  nibble_serial_adder #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model(
    input logic [W-1:0] a,
    input logic [W-1:0] b,
    input logic         sub
  );
    exp_t   e;
    longint sa;
    longint sb;
    longint sr;
    logic [W:0] u;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    sr  = sub ? sa - sb : sa + sb;
    u   = sub ? {1'b0, a} - {1'b0, b} : {1'b0, a} + {1'b0, b};
    e.r = u[W-1:0];
    e.c = sub ? (a >= b) : u[W];
    e.v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    e.z = (e.r == '0);
    return e;
  endfunction

  task automatic chk(input string nm, input logic [W-1:0] act,
                     input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, req, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    failures++;
    $display("FAIL %s t=%0t", nm, $time);
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic sub);
    int n;
    bit acc;
    n   = 0;
    acc = 0;
    bus.a        = a;
    bus.b        = b;
    bus.op_sub   = sub;
    bus.in_valid = 1'b1;
    while (!acc && n < 400) begin
      @(negedge clk);
      if (bus.in_ready) begin
        acc = 1;
        exp_q.push_back(model(a, b, sub));
        acc_q.push_back(cyc + 1);
        if (b2b && last_acc >= 0)
          chk("init_interval", W'(cyc + 1 - last_acc), W'(NIB + 2));
        last_acc = cyc + 1;
      end
      n++;
    end
    if (!acc) fail_now("accept_timeout");
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.a        = $urandom;
    bus.b        = $urandom;
    bus.op_sub   = 1'($urandom_range(0, 1));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 600) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) fail_now("drain_timeout");
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // monitor: latency at out_valid rise, scoreboard compare on handshake
  initial begin
    bit prev;
    int run;
    exp_t e;
    prev = 0;
    run  = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev = 0;
        run  = 0;
        continue;
      end
      if (bus.out_valid) run++;
      else run = 0;
      if (bus.out_valid && !prev) begin
        if (acc_q.size() == 0) fail_now("unexpected_out_valid");
        else chk("latency", W'(cyc - acc_q.pop_front()), W'(NIB));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_result");
        end else begin
          e = exp_q.pop_front();
          chk("result", bus.result, e.r);
          chk("carry_out", W'(bus.carry_out), W'(e.c));
          chk("overflow", W'(bus.overflow), W'(e.v));
          chk("zero", W'(bus.zero), W'(e.z));
          if (b2b) chk("out_valid_width", W'(run), W'(1));
        end
      end
      prev = bus.out_valid;
    end
  end

  // random backpressure source
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd) bus.out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] snap_r;
    logic         snap_c;
    logic         snap_v;
    logic         snap_z;
    int           n;
    checks       = 0;
    failures     = 0;
    cyc          = 0;
    last_acc     = -1;
    b2b          = 0;
    rnd          = 0;
    reset_n      = 1'b0;
    bus.in_valid = 1'b0;
    bus.op_sub   = 1'b0;
    bus.a        = '0;
    bus.b        = '0;
    bus.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", W'(bus.in_ready), '0);
    chk("rst_out_valid", W'(bus.out_valid), '0);
    chk("rst_result", bus.result, '0);
    chk("rst_flags", W'({bus.carry_out, bus.overflow, bus.zero}), '0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("in_ready_after_rst", W'(bus.in_ready), W'(1));

    do_op(32'h0000_0001, 32'hFFFF_FFFF, 1'b0);
    do_op(32'd5, 32'd7, 1'b1);
    do_op(32'h7FFF_FFFF, 32'd1, 1'b0);
    do_op(32'h8000_0000, 32'd1, 1'b1);
    do_op(32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1);
    do_op(32'd0, 32'd0, 1'b1);
    drain();

    bus.out_ready = 1'b0;
    do_op(32'h0F0F_0F0F, 32'h1234_5678, 1'b0);
    n = 0;
    while (!bus.out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!bus.out_valid) fail_now("bp_wait_timeout");
    snap_r = bus.result;
    snap_c = bus.carry_out;
    snap_v = bus.overflow;
    snap_z = bus.zero;
    repeat (5) begin
      @(posedge clk);
      #1;
      bus.in_valid = 1'b1;
      bus.a        = $urandom;
      bus.b        = $urandom;
      bus.op_sub   = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("bp_result", bus.result, snap_r);
      chk("bp_flags", W'({bus.carry_out, bus.overflow, bus.zero}),
          W'({snap_c, snap_v, snap_z}));
      chk("bp_out_valid", W'(bus.out_valid), W'(1));
      chk("bp_in_ready", W'(bus.in_ready), '0);
    end
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("in_ready_after_hs", W'(bus.in_ready), W'(1));
    chk("out_valid_after_hs", W'(bus.out_valid), '0);
    do_op(32'hFFFF_FFF0, 32'h0000_0020, 1'b0);
    drain();

    bus.a        = 32'h1234_5678;
    bus.b        = 32'h1111_1111;
    bus.op_sub   = 1'b0;
    bus.in_valid = 1'b1;
    @(negedge clk);
    chk("mid_rst_pre_ready", W'(bus.in_ready), W'(1));
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk("abort_in_ready", W'(bus.in_ready), '0);
    chk("abort_out_valid", W'(bus.out_valid), '0);
    chk("abort_result", bus.result, '0);
    chk("abort_flags", W'({bus.carry_out, bus.overflow, bus.zero}), '0);
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("in_ready_after_abort", W'(bus.in_ready), W'(1));
    do_op(32'h1234_5678, 32'h1111_1111, 1'b0);
    drain();

    b2b      = 1;
    last_acc = -1;
    do_op(32'h0000_FFFF, 32'h0000_0001, 1'b0);
    do_op(32'h1000_0000, 32'h2000_0000, 1'b1);
    do_op(32'hCAFE_F00D, 32'h0BAD_BEEF, 1'b0);
    drain();
    b2b = 0;

    rnd = 1;
    for (int i = 0; i < 40; i++)
      do_op(pick(), pick(), 1'($urandom_range(0, 1)));
    drain();
    rnd = 0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    chk("scoreboard_empty", W'(exp_q.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
